// File: rtl/direct_mapped_cache_pkg.sv
// rtl/direct_mapped_cache_pkg.sv - shared FSM encoding and address-split width helpers
package direct_mapped_cache_pkg;

    localparam int DEFAULT_LINES      = 64;
    localparam int DEFAULT_LINE_WORDS = 4;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_REFILL_REQ  = 3'd1,
        ST_REFILL_WAIT = 3'd2,
        ST_RESPOND     = 3'd3,
        ST_WRITE       = 3'd4
    } cache_state_e;

    function automatic int offset_width(input int line_words);
        return $clog2(line_words);
    endfunction

    function automatic int index_width(input int lines);
        return $clog2(lines);
    endfunction

    // Byte address minus the 2 byte-select bits, the offset and the index.
    function automatic int tag_width(input int lines, input int line_words);
        return 30 - $clog2(lines) - $clog2(line_words);
    endfunction

endpackage

// File: rtl/direct_mapped_cache_data_array.sv
// rtl/direct_mapped_cache_data_array.sv - synchronous-read word SRAM with per-byte write enables
module direct_mapped_cache_data_array #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    input  logic [3:0]        we,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (we[b]) begin
                mem_q[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
        rdata_q <= mem_q[addr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/direct_mapped_cache.sv
// rtl/direct_mapped_cache.sv - direct-mapped, write-through, no-write-allocate cache with line refill
module direct_mapped_cache
    import direct_mapped_cache_pkg::*;
#(
    parameter int LINES      = DEFAULT_LINES,
    parameter int LINE_WORDS = DEFAULT_LINE_WORDS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] cpu_addr,
    input  logic        cpu_re,
    input  logic [3:0]  cpu_we,
    input  logic [31:0] cpu_din,
    output logic [31:0] cpu_dout,
    output logic        stall,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_req_rnw,
    output logic [31:0] mem_req_addr,
    output logic [31:0] mem_req_data,
    output logic [3:0]  mem_req_mask,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data
);

    localparam int OFF_W   = offset_width(LINE_WORDS);
    localparam int IDX_W   = index_width(LINES);
    localparam int TAG_W   = tag_width(LINES, LINE_WORDS);
    localparam int SRAM_AW = IDX_W + OFF_W;
    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);
    localparam logic [OFF_W-1:0] BEAT_ONE  = OFF_W'(1);

    cache_state_e      state_q, state_d;
    logic [31:2]       addr_q, addr_d;
    logic [31:0]       din_q, din_d;
    logic [3:0]        we_q, we_d;
    logic [OFF_W-1:0]  beat_q, beat_d;
    logic [31:0]       word_q, word_d;
    logic [31:0]       dout_q, dout_d;
    logic              sel_sram_q, sel_sram_d;
    logic [LINES-1:0]  valid_q, valid_d;
    logic [TAG_W-1:0]  tag_q [LINES];
    logic [TAG_W-1:0]  tag_d [LINES];

    logic [OFF_W-1:0]   cpu_off, lat_off;
    logic [IDX_W-1:0]   cpu_idx, lat_idx;
    logic [TAG_W-1:0]   cpu_tag, lat_tag;
    logic               cpu_wr, cpu_hit, accept;
    logic [SRAM_AW-1:0] sram_addr;
    logic [3:0]         sram_we;
    logic [31:0]        sram_wdata, sram_rdata;
    logic               unused_addr_bits;

    assign cpu_off = cpu_addr[OFF_W+1:2];
    assign cpu_idx = cpu_addr[OFF_W+2 +: IDX_W];
    assign cpu_tag = cpu_addr[31 -: TAG_W];
    assign lat_off = addr_q[OFF_W+1:2];
    assign lat_idx = addr_q[OFF_W+2 +: IDX_W];
    assign lat_tag = addr_q[31 -: TAG_W];
    assign unused_addr_bits = ^cpu_addr[1:0];

    assign cpu_wr  = |cpu_we;
    assign cpu_hit = valid_q[cpu_idx] && (tag_q[cpu_idx] == cpu_tag);
    // RESPOND runs with stall low, so the core may issue its next access then.
    assign accept  = ((state_q == ST_IDLE) || (state_q == ST_RESPOND)) && (cpu_re || cpu_wr);

    assign stall         = (state_q == ST_REFILL_REQ) || (state_q == ST_REFILL_WAIT) ||
                           (state_q == ST_WRITE);
    assign mem_req_valid = (state_q == ST_REFILL_REQ) || (state_q == ST_WRITE);
    assign mem_req_rnw   = (state_q != ST_WRITE);
    assign mem_req_addr  = mem_req_rnw ? {addr_q[31:OFF_W+2], {(OFF_W+2){1'b0}}}
                                       : {addr_q, 2'b00};
    assign mem_req_data  = din_q;
    assign mem_req_mask  = we_q;
    assign cpu_dout      = sel_sram_q ? sram_rdata : dout_q;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        din_d      = din_q;
        we_d       = we_q;
        beat_d     = beat_q;
        word_d     = word_q;
        dout_d     = sel_sram_q ? sram_rdata : dout_q;
        sel_sram_d = 1'b0;
        valid_d    = valid_q;
        tag_d      = tag_q;
        sram_addr  = {cpu_idx, cpu_off};
        sram_we    = 4'b0000;
        sram_wdata = cpu_din;

        unique case (state_q)
            ST_REFILL_REQ: begin
                if (mem_req_ready) begin
                    state_d = ST_REFILL_WAIT;
                end
            end
            ST_REFILL_WAIT: begin
                sram_addr  = {lat_idx, beat_q};
                sram_wdata = mem_resp_data;
                if (mem_resp_valid) begin
                    sram_we = 4'b1111;
                    beat_d  = beat_q + BEAT_ONE;
                    if (beat_q == lat_off) begin
                        word_d = mem_resp_data;
                    end
                    if (beat_q == LAST_BEAT) begin
                        valid_d[lat_idx] = 1'b1;
                        tag_d[lat_idx]   = lat_tag;
                        dout_d  = (beat_q == lat_off) ? mem_resp_data : word_q;
                        state_d = ST_RESPOND;
                    end
                end
            end
            ST_RESPOND: state_d = ST_IDLE;
            ST_WRITE: begin
                if (mem_req_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A write alongside a read takes priority; the read is dropped.
        if (accept) begin
            addr_d = cpu_addr[31:2];
            if (cpu_wr) begin
                din_d   = cpu_din;
                we_d    = cpu_we;
                state_d = ST_WRITE;
                if (cpu_hit) begin
                    sram_we = cpu_we;
                end
            end else if (cpu_hit) begin
                sel_sram_d = 1'b1;
                state_d    = ST_IDLE;
            end else begin
                beat_d  = '0;
                state_d = ST_REFILL_REQ;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            din_q      <= '0;
            we_q       <= '0;
            beat_q     <= '0;
            word_q     <= '0;
            dout_q     <= '0;
            sel_sram_q <= 1'b0;
            valid_q    <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            din_q      <= din_d;
            we_q       <= we_d;
            beat_q     <= beat_d;
            word_q     <= word_d;
            dout_q     <= dout_d;
            sel_sram_q <= sel_sram_d;
            valid_q    <= valid_d;
        end
    end

    // Tags are only meaningful under their valid bit, so they need no reset.
    always_ff @(posedge clk) begin
        tag_q <= tag_d;
    end

    direct_mapped_cache_data_array #(
        .ADDR_W(SRAM_AW)
    ) u_data_array (
        .clk  (clk),
        .addr (sram_addr),
        .we   (sram_we),
        .wdata(sram_wdata),
        .rdata(sram_rdata)
    );

endmodule

// File: tb/tb_direct_mapped_cache.sv
// tb/tb_direct_mapped_cache.sv - vector table plus scoreboarded memory responder for direct_mapped_cache
module tb_direct_mapped_cache;

    localparam int LINES      = 64;
    localparam int LINE_WORDS = 4;
    localparam logic [31:0] LINE_MASK = 32'(LINE_WORDS * 4 - 1);

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] cpu_addr;
    logic        cpu_re;
    logic [3:0]  cpu_we;
    logic [31:0] cpu_din;
    logic [31:0] cpu_dout;
    logic        stall;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_req_rnw;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_data;
    logic [3:0]  mem_req_mask;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;

    always #5 clk = ~clk;

    direct_mapped_cache #(
        .LINES(LINES),
        .LINE_WORDS(LINE_WORDS)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .cpu_addr      (cpu_addr),
        .cpu_re        (cpu_re),
        .cpu_we        (cpu_we),
        .cpu_din       (cpu_din),
        .cpu_dout      (cpu_dout),
        .stall         (stall),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_rnw   (mem_req_rnw),
        .mem_req_addr  (mem_req_addr),
        .mem_req_data  (mem_req_data),
        .mem_req_mask  (mem_req_mask),
        .mem_resp_valid(mem_resp_valid),
        .mem_resp_data (mem_resp_data)
    );

    typedef struct {
        logic [31:0] addr;
        logic        re;
        logic [3:0]  we;
        logic [31:0] din;
        logic        miss;
        logic [31:0] dout;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  mask;
    } wr_t;

    int          n_vec = 0;
    int          n_bad = 0;
    int          ready_block = 0;
    logic [31:0] last_dout = 32'h0;
    logic [31:0] exp_refill_q [$];
    wr_t         exp_wr_q [$];
    logic [31:0] mem_store [logic [31:0]];

    function automatic logic [31:0] mem_init(input logic [31:0] a);
        return 32'hA0 + {30'd0, a[3:2]} + ((a >> 4) - 32'd1) * 32'h100;
    endfunction

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        return mem_store.exists(a) ? mem_store[a] : mem_init(a);
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    // Memory model: accepts requests, streams refill beats, applies write-through data.
    initial begin : responder
        logic        fire, rfire, rnw;
        logic [31:0] a, d, w, base;
        logic [3:0]  m;
        wr_t         e;
        int          beat, left;
        beat = 0; left = 0; base = 0;
        mem_req_ready = 1'b1; mem_resp_valid = 1'b0; mem_resp_data = 32'h0;
        forever begin
            @(negedge clk);
            fire  = mem_req_valid && mem_req_ready;
            rnw   = mem_req_rnw;
            a     = mem_req_addr;
            d     = mem_req_data;
            m     = mem_req_mask;
            rfire = mem_resp_valid;
            @(posedge clk);
            #1;
            if (reset) begin
                left = 0; beat = 0;
                mem_resp_valid = 1'b0; mem_resp_data = 32'h0; mem_req_ready = 1'b1;
                continue;
            end
            if (rfire) begin
                beat++; left--;
            end
            if (fire && rnw) begin
                check("refill_req_expected", 32'(exp_refill_q.size() != 0), 32'd1);
                if (exp_refill_q.size() != 0) check("refill_addr", a, exp_refill_q.pop_front());
                base = a; beat = 0; left = LINE_WORDS;
            end else if (fire) begin
                check("write_req_expected", 32'(exp_wr_q.size() != 0), 32'd1);
                if (exp_wr_q.size() != 0) begin
                    e = exp_wr_q.pop_front();
                    check("write_addr", a, e.addr);
                    check("write_data", d, e.data);
                    check("write_mask", 32'(m), 32'(e.mask));
                end
                w = mem_read(a);
                for (int b = 0; b < 4; b++) if (m[b]) w[8*b +: 8] = d[8*b +: 8];
                mem_store[a] = w;
            end
            mem_resp_valid = (left > 0);
            mem_resp_data  = (left > 0) ? mem_read(base + 32'(4 * beat)) : 32'h0;
            if (mem_req_valid && ready_block > 0) begin
                mem_req_ready = 1'b0;
                ready_block--;
            end else begin
                mem_req_ready = 1'b1;
            end
        end
    end

    // A request held off by ready must not change until it is accepted.
    initial begin : stability
        logic        held, prnw;
        logic [31:0] pa, pd;
        logic [3:0]  pm;
        held = 1'b0; prnw = 1'b0; pa = 0; pd = 0; pm = 0;
        forever begin
            @(negedge clk);
            if (held && !reset) begin
                check("hold_valid", 32'(mem_req_valid), 32'd1);
                check("hold_rnw", 32'(mem_req_rnw), 32'(prnw));
                check("hold_addr", mem_req_addr, pa);
                check("hold_data", mem_req_data, pd);
                check("hold_mask", 32'(mem_req_mask), 32'(pm));
            end
            held = mem_req_valid && !mem_req_ready;
            prnw = mem_req_rnw; pa = mem_req_addr; pd = mem_req_data; pm = mem_req_mask;
        end
    end

    // Called at a negedge with stall low; returns at a negedge with stall low.
    task automatic apply(input vec_t v, input string nm, output int waited);
        cpu_addr = v.addr; cpu_re = v.re; cpu_we = v.we; cpu_din = v.din;
        if (v.we != 4'h0) exp_wr_q.push_back('{v.addr & ~32'h3, v.din, v.we});
        else if (v.miss) exp_refill_q.push_back(v.addr & ~LINE_MASK);
        @(negedge clk);
        cpu_re = 1'b0; cpu_we = 4'h0;
        check({nm, "_stall"}, 32'(stall), 32'((v.we != 4'h0) || v.miss));
        if (v.we != 4'h0) begin
            check({nm, "_dout_hold"}, cpu_dout, last_dout);
        end else if (!v.miss) begin
            check({nm, "_dout"}, cpu_dout, v.dout);
            last_dout = v.dout;
        end
        waited = 0;
        while (stall === 1'b1 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check({nm, "_stall_release"}, 32'(stall), 32'd0);
        if (v.miss && v.we == 4'h0) begin
            check({nm, "_dout"}, cpu_dout, v.dout);
            last_dout = v.dout;
        end
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        vec_t tbl [16];
        vec_t post [2];
        vec_t v;
        int   waited, beats, guard;

        tbl[0]  = '{32'h0000_0010, 1'b1, 4'b0000, 32'h0,         1'b1, 32'h0000_00A0};
        tbl[1]  = '{32'h0000_0014, 1'b1, 4'b0000, 32'h0,         1'b0, 32'h0000_00A1};
        tbl[2]  = '{32'h0000_0018, 1'b1, 4'b0000, 32'h0,         1'b0, 32'h0000_00A2};
        tbl[3]  = '{32'h0000_001C, 1'b1, 4'b0000, 32'h0,         1'b0, 32'h0000_00A3};
        tbl[4]  = '{32'h0000_0014, 1'b0, 4'b0010, 32'h0000_5500, 1'b0, 32'h0};
        tbl[5]  = '{32'h0000_0014, 1'b1, 4'b0000, 32'h0,         1'b0, 32'h0000_55A1};
        tbl[6]  = '{32'h0000_0410, 1'b1, 4'b0000, 32'h0,         1'b1, 32'h0000_40A0};
        tbl[7]  = '{32'h0000_0010, 1'b1, 4'b0000, 32'h0,         1'b1, 32'h0000_00A0};
        tbl[8]  = '{32'h0000_0024, 1'b0, 4'b1111, 32'hDEAD_BEEF, 1'b0, 32'h0};
        tbl[9]  = '{32'h0000_0024, 1'b1, 4'b0000, 32'h0,         1'b1, 32'hDEAD_BEEF};
        tbl[10] = '{32'h0000_0014, 1'b1, 4'b0000, 32'h0,         1'b0, 32'h0000_55A1};
        tbl[11] = '{32'h0000_0018, 1'b1, 4'b0001, 32'h0000_0077, 1'b0, 32'h0};
        tbl[12] = '{32'h0000_001B, 1'b1, 4'b0000, 32'h0,         1'b0, 32'h0000_0077};
        tbl[13] = '{32'h0000_0030, 1'b1, 4'b0000, 32'h0,         1'b1, 32'h0000_02A0};
        tbl[14] = '{32'h0000_0034, 1'b0, 4'b1111, 32'h1234_5678, 1'b0, 32'h0};
        tbl[15] = '{32'h0000_0034, 1'b1, 4'b0000, 32'h0,         1'b0, 32'h1234_5678};
        post[0] = '{32'h0000_0050, 1'b1, 4'b0000, 32'h0,         1'b1, 32'h0000_04A0};
        post[1] = '{32'h0000_0010, 1'b1, 4'b0000, 32'h0,         1'b1, 32'h0000_00A0};

        reset = 1'b1; cpu_addr = 0; cpu_re = 1'b0; cpu_we = 4'h0; cpu_din = 0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("reset_stall", 32'(stall), 32'd0);
        check("reset_mem_req_valid", 32'(mem_req_valid), 32'd0);
        check("reset_cpu_dout", cpu_dout, 32'h0);

        foreach (tbl[i]) apply(tbl[i], $sformatf("v%0d", i), waited);

        // Backpressure: five ready-low cycles, then the handshake cycle, then IDLE.
        ready_block = 5;
        v = '{32'h0000_0038, 1'b0, 4'b1100, 32'hAABB_0000, 1'b0, 32'h0};
        apply(v, "bp_write", waited);
        check("bp_stall_cycles", 32'(waited), 32'd6);
        v = '{32'h0000_0038, 1'b1, 4'b0000, 32'h0, 1'b0, 32'hAABB_02A2};
        apply(v, "bp_read", waited);

        // Reset after two refill beats have been consumed.
        cpu_addr = 32'h0000_0050; cpu_re = 1'b1;
        exp_refill_q.push_back(32'h0000_0050);
        @(negedge clk);
        cpu_re = 1'b0;
        beats = 0; guard = 0;
        while (beats < 2 && guard < 100) begin
            if (mem_resp_valid) beats++;
            @(negedge clk);
            guard++;
        end
        check("abort_beats_seen", 32'(beats), 32'd2);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_stall", 32'(stall), 32'd0);
        check("abort_mem_req_valid", 32'(mem_req_valid), 32'd0);
        check("abort_cpu_dout", cpu_dout, 32'h0);
        last_dout = 32'h0;
        foreach (post[i]) apply(post[i], $sformatf("post%0d", i), waited);

        repeat (2) @(negedge clk);
        check("refill_queue_drained", 32'(exp_refill_q.size()), 32'd0);
        check("write_queue_drained", 32'(exp_wr_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
